// File: rtl/irs_sample_read_sequencer.sv
// irs_sample_read_sequencer: steps the IRS3B read address through one channel and streams latched samples.
module irs_sample_read_sequencer #(
  parameter int NUM_SAMPLES    = 64,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  ch_sel_i,
  output logic        busy_o,
  output logic        addr_start_o,
  output logic        addr_mode_o,
  output logic [2:0]  addr_ch_o,
  input  logic        addr_reached_i,
  output logic        irs_smpall_o,
  input  logic [11:0] irs_dat_i,
  output logic [11:0] dat_o,
  output logic [5:0]  sample_o,
  output logic [2:0]  ch_o,
  output logic        valid_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic        done_o,
  output logic        timeout_o
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_REQ  = 3'd1;
  localparam logic [2:0] STEP_REQ  = 3'd2;
  localparam logic [2:0] WAIT_ADDR = 3'd3;
  localparam logic [2:0] SETTLE    = 3'd4;
  localparam logic [2:0] OUT_WAIT  = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;
  localparam logic [5:0] LAST_SAMPLE = 6'(NUM_SAMPLES - 1);
  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] TIMEOUT     = 10'(TIMEOUT_CYCLES);
  logic [2:0] state;
  logic [9:0] cnt;
  assign busy_o       = state != IDLE;
  assign irs_smpall_o = busy_o;
  assign addr_start_o = state == LOAD_REQ || state == STEP_REQ;
  assign addr_mode_o  = state == LOAD_REQ;
  assign addr_ch_o    = ch_o;
  assign done_o       = state == DONE;
  // cnt serves both as the shifter wait timer and as the settle timer
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      dat_o     <= '0;
      sample_o  <= '0;
      ch_o      <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start_i) begin
            ch_o      <= ch_sel_i;
            sample_o  <= '0;
            timeout_o <= 1'b0;
            state     <= LOAD_REQ;
          end
        LOAD_REQ, STEP_REQ: begin
          cnt   <= '0;
          state <= WAIT_ADDR;
        end
        WAIT_ADDR:
          if (addr_reached_i) begin
            cnt   <= '0;
            state <= SETTLE;
          end else if (cnt == TIMEOUT) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else
            cnt <= cnt + 10'd1;
        SETTLE:
          if (cnt == SETTLE_LAST) begin
            dat_o   <= irs_dat_i;
            valid_o <= 1'b1;
            last_o  <= sample_o == LAST_SAMPLE;
            state   <= OUT_WAIT;
          end else
            cnt <= cnt + 10'd1;
        OUT_WAIT:
          if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            if (last_o)
              state <= DONE;
            else begin
              sample_o <= sample_o + 6'd1;
              state    <= STEP_REQ;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule
